pl_irq_scheduler: RTL and testbench
===================================

PL_IRQ_SCHEDULER -- requirements
Module: pl_irq_scheduler

Interface
REQ-001 SHALL provide parameter N_SRC, default 4: number of interrupt request sources (2..16).
REQ-002 SHALL provide parameter ID_W, default 2: width of source index, ceil(log2(N_SRC)).
REQ-003 SHALL provide parameter PULSE_CYC, default 200: Irq_out high time in cycles (1 us at 200 MHz).
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 200000: ack wait limit in cycles (1 ms at 200 MHz).
REQ-005 SHALL provide parameter CNT_W, default 20: width of the shared pulse/timeout counter.
REQ-006 Sys_clk  in  1  sole clock; all logic on rising edge.
REQ-007 Rst  in  1  reset; synchronous, active-high.
REQ-008 Irq_req  in  N_SRC  per-source request; a rising edge is one event.
REQ-009 Irq_ack  in  1  PS acknowledge, single-cycle pulse.
REQ-010 Ovr_clr  in  1  clears all Overrun bits.
REQ-011 Irq_out  out  1  interrupt line to PS.
REQ-012 Irq_id  out  ID_W  index of the source in service; valid while Busy=1.
REQ-013 Busy  out  1  high in any state other than IDLE.
REQ-014 Pending  out  N_SRC  latched, not-yet-serviced events.
REQ-015 Overrun  out  N_SRC  sticky: event lost on that source.
REQ-016 Timeout_flag  out  1  sticky ack-timeout indicator (present only with IRQ_TIMEOUT_EN).

Function
REQ-017 SHALL register Irq_req once; an edge is req=1 with previous sample 0; edge sampled at cycle k sets Pending bit at k+1.
REQ-018 SHALL implement FSM IDLE -> PULSE -> WAIT_ACK -> IDLE.
REQ-019 IDLE: if Pending!=0, SHALL grant lowest-index pending source, load Irq_id, clear that Pending bit, enter PULSE; Irq_out rises the cycle after grant.
REQ-020 PULSE: SHALL hold Irq_out=1 for exactly PULSE_CYC cycles, then drop it and enter WAIT_ACK.
REQ-021 An Irq_ack during PULSE SHALL be remembered; PULSE then exits directly to IDLE, skipping WAIT_ACK.
REQ-022 WAIT_ACK: Irq_ack SHALL return FSM to IDLE next cycle; new grant no earlier than the cycle after that.
REQ-023 Irq_ack in IDLE SHALL be ignored.
REQ-024 Edge on a source whose Pending bit is already 1 SHALL set its Overrun bit; Pending stays 1.
REQ-025 Edge on a source in the same cycle its Pending bit is cleared by grant SHALL leave Pending=1, no Overrun.
REQ-026 Edge on the source in service (Pending=0) SHALL set Pending, not Overrun.
REQ-027 Ovr_clr coincident with a new overrun on a bit SHALL leave that bit set.
REQ-028 Counter SHALL saturate, never wrap; PULSE_CYC and TIMEOUT_CYC SHALL fit in CNT_W.

Reset
REQ-029 Rst SHALL force IDLE, counter 0, Irq_out=0, Irq_id=0, Busy=0, Pending=0, Overrun=0, Timeout_flag=0, edge register=0.
REQ-030 Irq_req held high across reset release SHALL count as one edge in the first post-reset cycle.
REQ-031 Rst mid-PULSE SHALL drop Irq_out the next cycle; pending events are discarded.

Configuration
REQ-032 Macro IRQ_TIMEOUT_EN defined: WAIT_ACK exits to IDLE after TIMEOUT_CYC cycles without ack, setting Timeout_flag (cleared only by Rst); ack on the expiry cycle wins, no flag.
REQ-033 Macro IRQ_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely; Timeout_flag port absent.

Structure
REQ-034 Package pl_irq_pkg SHALL hold state encoding constants (IDLE=0, PULSE=1, WAIT_ACK=2) and default parameter values.
REQ-035 Edge detect + Pending/Overrun bookkeeping SHALL be sub-module pl_irq_edge_latch, instantiated once, N_SRC wide.

Verification (N_SRC=4, PULSE_CYC=4, TIMEOUT_CYC=16)
REQ-036 Edge on Irq_req[2] at cycle 10 -> Pending[2]=1 at 11, grant at 11, Irq_out high cycles 12-15, Irq_id=2; ack at 20 -> Busy=0 at 21.
REQ-037 Edges on [3] and [1] same cycle -> [1] serviced first, then [3] after ack; no Overrun.
REQ-038 Two edges on [0] while Pending[0]=1 -> Overrun[0]=1; Ovr_clr clears it; Ovr_clr with new overrun same cycle -> stays 1.
REQ-039 Ack during PULSE -> Irq_out still exactly 4 cycles, FSM returns to IDLE without WAIT_ACK.
REQ-040 With IRQ_TIMEOUT_EN, no ack -> IDLE 16 cycles after PULSE ends, Timeout_flag=1; without macro FSM remains in WAIT_ACK.
REQ-041 Rst asserted during PULSE cycle 2 -> Irq_out=0, Pending=0, Busy=0 next cycle.

Source files
------------

// File: rtl/pl_irq_pkg.sv
// Shared state encoding, default parameters and the priority helper for the
// PL interrupt scheduler.
package pl_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2
    } irq_state_e;

    localparam int DEF_N_SRC       = 4;
    localparam int DEF_ID_W        = 2;
    localparam int DEF_PULSE_CYC   = 200;
    localparam int DEF_TIMEOUT_CYC = 200000;
    localparam int DEF_CNT_W       = 20;

    // Lowest set index of a (zero-extended) request vector; 0 when empty.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

endpackage

// File: rtl/pl_irq_edge_latch.sv
// Rising-edge detection on every request line plus Pending/Overrun bookkeeping.
module pl_irq_edge_latch
    import pl_irq_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC
) (
    input  logic             Sys_clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [N_SRC-1:0] grant_clr,
    input  logic             ovr_clr,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun
);

    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] lost;

    // req_q resets to 0 so a request held across reset release is one edge.
    assign edge_det = irq_req & ~req_q;
    // An edge only overruns if its pending bit survives this cycle.
    assign lost     = edge_det & pending & ~grant_clr;

    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            req_q   <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            req_q   <= irq_req;
            pending <= (pending & ~grant_clr) | edge_det;
            overrun <= (overrun & ~{N_SRC{ovr_clr}}) | lost;
        end
    end

endmodule

// File: rtl/pl_irq_scheduler.sv
// Serialises N_SRC edge-triggered requests onto one pulsed PS interrupt line.
// Define IRQ_TIMEOUT_EN to bound the ack wait and expose Timeout_flag.
module pl_irq_scheduler
    import pl_irq_pkg::*;
#(
    parameter int N_SRC       = DEF_N_SRC,
    parameter int ID_W        = DEF_ID_W,
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             Sys_clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] Irq_req,
    input  logic             Irq_ack,
    input  logic             Ovr_clr,
    output logic             Irq_out,
    output logic [ID_W-1:0]  Irq_id,
    output logic             Busy,
`ifdef IRQ_TIMEOUT_EN
    output logic             Timeout_flag,
`endif
    output logic [N_SRC-1:0] Pending,
    output logic [N_SRC-1:0] Overrun
);

    // Counter stops at the largest limit it is ever compared against.
    localparam int CNT_SAT_I = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_SAT_I);
    localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(PULSE_CYC);
`ifdef IRQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYC);
`endif

    irq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ack_seen;
    logic             grant_en;
    logic [3:0]       gidx;
    logic [N_SRC-1:0] grant_clr;

    pl_irq_edge_latch #(.N_SRC(N_SRC)) u_edge_latch (
        .Sys_clk   (Sys_clk),
        .Rst       (Rst),
        .irq_req   (Irq_req),
        .grant_clr (grant_clr),
        .ovr_clr   (Ovr_clr),
        .pending   (Pending),
        .overrun   (Overrun)
    );

    assign grant_en = (state == IDLE) && (|Pending);
    assign gidx     = lowest_idx(16'(Pending));
    assign cnt_inc  = (cnt >= CNT_SAT) ? cnt : cnt + CNT_W'(1);
    assign Busy     = (state != IDLE);

    always_comb begin
        grant_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_clr[i] = grant_en && (gidx == 4'(i));
        end
    end

    // cnt holds the 1-based index of the current cycle within PULSE / WAIT_ACK.
    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            Irq_out  <= 1'b0;
            Irq_id   <= '0;
            ack_seen <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            Timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        state    <= PULSE;
                        Irq_id   <= ID_W'(gidx);
                        Irq_out  <= 1'b1;
                        cnt      <= CNT_W'(1);
                        ack_seen <= 1'b0;
                    end
                end
                PULSE: begin
                    if (cnt >= PULSE_LIM) begin
                        Irq_out <= 1'b0;
                        if (ack_seen || Irq_ack) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT_ACK;
                            cnt   <= CNT_W'(1);
                        end
                    end else begin
                        cnt      <= cnt_inc;
                        ack_seen <= ack_seen | Irq_ack;
                    end
                end
                WAIT_ACK: begin
                    if (Irq_ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
`ifdef IRQ_TIMEOUT_EN
                    else if (cnt >= TO_LIM) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        Timeout_flag <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    Irq_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pl_irq_scheduler.sv
// Directed plus random stimulus against an event-level reference model.
module tb_pl_irq_scheduler;

    localparam int N = 4;
    localparam int P = 4;
    localparam int T = 16;

    logic       Sys_clk = 1'b0;
    logic       Rst = 1'b1;
    logic [3:0] Irq_req = '0;
    logic       Irq_ack = 1'b0;
    logic       Ovr_clr = 1'b0;
    logic       Irq_out;
    logic [1:0] Irq_id;
    logic       Busy;
    logic [3:0] Pending;
    logic [3:0] Overrun;
`ifdef IRQ_TIMEOUT_EN
    logic       Timeout_flag;
`endif

    pl_irq_scheduler #(
        .N_SRC(N), .ID_W(2), .PULSE_CYC(P), .TIMEOUT_CYC(T), .CNT_W(20)
    ) dut (
        .Sys_clk (Sys_clk),
        .Rst     (Rst),
        .Irq_req (Irq_req),
        .Irq_ack (Irq_ack),
        .Ovr_clr (Ovr_clr),
        .Irq_out (Irq_out),
        .Irq_id  (Irq_id),
        .Busy    (Busy),
`ifdef IRQ_TIMEOUT_EN
        .Timeout_flag (Timeout_flag),
`endif
        .Pending (Pending),
        .Overrun (Overrun)
    );

    always #5 Sys_clk = ~Sys_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 pulsing, 2 waiting for ack.
    logic [3:0] m_prev = '0, m_pend = '0, m_ovr = '0;
    logic [1:0] m_id = '0;
    int         m_phase = 0, m_hi = 0, m_wait = 0;
    bit         m_acked = 0, m_out = 0, m_tflag = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] req, input logic ack, input logic oclr);
        logic [3:0] edges;
        logic [3:0] grant;
        if (r) begin
            m_prev = '0; m_pend = '0; m_ovr = '0; m_id = '0;
            m_phase = 0; m_hi = 0; m_wait = 0;
            m_acked = 0; m_out = 0; m_tflag = 0;
            return;
        end
        edges = req & ~m_prev;
        grant = '0;
        case (m_phase)
            0: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i]) m_id = 2'(i);
                end
                if (m_pend != 0) begin
                    grant[m_id] = 1'b1;
                    m_phase = 1; m_hi = 1; m_out = 1; m_acked = 0;
                end
            end
            1: begin
                if (m_hi == P) begin
                    m_out = 0;
                    m_phase = (m_acked || ack) ? 0 : 2;
                    m_wait = 0;
                end else begin
                    m_hi++;
                    if (ack) m_acked = 1;
                end
            end
            default: begin
                if (ack) m_phase = 0;
                else begin
                    m_wait++;
`ifdef IRQ_TIMEOUT_EN
                    if (m_wait == T) begin
                        m_phase = 0;
                        m_tflag = 1;
                    end
`endif
                end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (oclr) m_ovr[i] = 1'b0;
            if (edges[i]) begin
                // Event lost only if the earlier one is still waiting afterwards.
                if (m_pend[i] && !grant[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
            end else if (grant[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        m_prev = req;
    endtask

    task automatic cyc(input logic r, input logic [3:0] req, input logic ack, input logic oclr);
        Rst = r; Irq_req = req; Irq_ack = ack; Ovr_clr = oclr;
        model_step(r, req, ack, oclr);
        @(posedge Sys_clk);
        #1;
        chk("irq_out", 32'(Irq_out), 32'(m_out));
        chk("busy",    32'(Busy),    32'(m_phase != 0));
        chk("irq_id",  32'(Irq_id),  32'(m_id));
        chk("pending", 32'(Pending), 32'(m_pend));
        chk("overrun", 32'(Overrun), 32'(m_ovr));
`ifdef IRQ_TIMEOUT_EN
        chk("tflag",   32'(Timeout_flag), 32'(m_tflag));
`endif
    endtask

    initial begin
        int hi;
        bit first_low;
        logic [3:0] rq;

        // Reset state
        cyc(1, 4'b0000, 0, 0);
        cyc(1, 4'b0000, 0, 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_pend", 32'(Pending), 0);
        chk("rst_out",  32'(Irq_out), 0);
        repeat (3) cyc(0, 4'b0000, 0, 0);

        // Single edge on [2]: pending next cycle, 4-cycle pulse, ack in WAIT_ACK
        cyc(0, 4'b0100, 0, 0);
        chk("e2_pend", 32'(Pending[2]), 1);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 4'b0100, 0, 0);
            if (Irq_out) hi++;
        end
        chk("e2_hi_cycles", 32'(hi), P);
        chk("e2_id", 32'(Irq_id), 2);
        chk("e2_waiting", 32'(Busy), 1);
        cyc(0, 4'b0000, 1, 0);
        chk("e2_ack_idle", 32'(Busy), 0);

        // Simultaneous edges on [3] and [1]: [1] wins, [3] after ack
        cyc(0, 4'b1010, 0, 0);
        cyc(0, 4'b1010, 0, 0);
        chk("pri_first", 32'(Irq_id), 1);
        repeat (6) cyc(0, 4'b1010, 0, 0);
        cyc(0, 4'b1010, 1, 0);
        cyc(0, 4'b1010, 0, 0);
        chk("pri_second", 32'(Irq_id), 3);
        chk("pri_no_ovr", 32'(Overrun), 0);
        repeat (6) cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);

        // Overrun on [0] while busy with [1], clear, then clear vs new overrun
        cyc(0, 4'b0010, 0, 0);
        cyc(0, 4'b0011, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0001, 0, 0);
        chk("ovr_set", 32'(Overrun[0]), 1);
        chk("ovr_pend_kept", 32'(Pending[0]), 1);
        cyc(0, 4'b0000, 0, 1);
        chk("ovr_clr", 32'(Overrun[0]), 0);
        cyc(0, 4'b0001, 0, 1);
        chk("ovr_clr_vs_new", 32'(Overrun[0]), 1);
        repeat (4) cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        repeat (10) cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 1);

        // Ack during PULSE: full-length pulse then straight back to idle
        cyc(0, 4'b1000, 0, 0);
        cyc(0, 4'b1000, 0, 0);
        hi = 1;
        first_low = 1;
        cyc(0, 4'b1000, 1, 0);
        for (int k = 0; k < 6; k++) begin
            if (Irq_out) hi++;
            else if (first_low) begin
                chk("ackp_idle", 32'(Busy), 0);
                first_low = 0;
            end
            cyc(0, 4'b1000, 0, 0);
        end
        chk("ackp_hi_cycles", 32'(hi), P);

        // No ack after pulse
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0100, 0, 0);
        repeat (30) cyc(0, 4'b0100, 0, 0);
`ifdef IRQ_TIMEOUT_EN
        chk("to_idle", 32'(Busy), 0);
        chk("to_flag", 32'(Timeout_flag), 1);
`else
        chk("noto_wait", 32'(Busy), 1);
`endif
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0);

        // Reset during second pulse cycle with events pending
        cyc(0, 4'b0011, 0, 0);
        cyc(0, 4'b0011, 0, 0);
        cyc(0, 4'b0011, 0, 0);
        cyc(1, 4'b0011, 0, 0);
        chk("rstp_out", 32'(Irq_out), 0);
        chk("rstp_pend", 32'(Pending), 0);
        chk("rstp_busy", 32'(Busy), 0);
        // Request held high across reset release counts once
        cyc(0, 4'b0011, 0, 0);
        chk("rst_hold_edge", 32'(Pending), 32'h3);

        // Random traffic
        rq = 4'b0011;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) rq = rq ^ 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, rq,
                ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
